// File: rtl/fetch_mem_ctrl.sv
// Front-end sequencer for a 32x8 single-port unified RAM: instruction fetch
// into IR plus load/store service from execute, data taking priority.
module fetch_mem_ctrl #(
    parameter int unsigned       AW       = 5,
    parameter int unsigned       DW       = 8,
    parameter logic [AW-1:0]     RESET_PC = '0
) (
    input  logic          CLOCK,
    input  logic          RESET_N,
    input  logic          init,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_d,
    output logic          mem_we,
    input  logic [DW-1:0] mem_q,
    output logic [DW-1:0] ir,
    output logic          ir_valid,
    input  logic          ir_ready,
    output logic [AW-1:0] pc_ir,
    input  logic          jmp_valid,
    input  logic [AW-1:0] jmp_addr,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic [DW-1:0] d_rdata,
    output logic          d_rvalid
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_F_MEM = 3'd1,
        S_F_CAP = 3'd2,
        S_D_MEM = 3'd3,
        S_D_CAP = 3'd4,
        S_D_WR  = 3'd5
    } state_e;

    state_e        state_q;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_d_q;
    logic          mem_we_q;
    logic [DW-1:0] ir_q;
    logic [AW-1:0] pc_ir_q;
    logic          ir_valid_q;
    logic [DW-1:0] d_rdata_q;
    logic          d_rvalid_q;
    logic          fetch_slot;
    logic          fetch_busy;

    // Data requests are accepted only from IDLE and never while the RAM image loads
    assign d_gnt = !init && (state_q == S_IDLE) && d_req;

    // Fetch may issue when IR is free or being consumed this edge; a jump this
    // cycle holds it off so the issued address and the captured pc agree
    assign fetch_slot = !jmp_valid && (!ir_valid_q || ir_ready);
    assign fetch_busy = (state_q == S_F_MEM) || (state_q == S_F_CAP);

    // Sequencer: state, PC, RAM port, IR and load-response registers
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            mem_addr_q <= '0;
            mem_d_q    <= '0;
            mem_we_q   <= 1'b0;
            ir_q       <= '0;
            pc_ir_q    <= '0;
            ir_valid_q <= 1'b0;
            d_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
        end else if (init) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            mem_we_q   <= 1'b0;
            ir_valid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            mem_we_q   <= 1'b0;
            d_rvalid_q <= 1'b0;
            if (ir_valid_q && ir_ready) begin
                ir_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (d_req) begin
                        mem_addr_q <= d_addr;
                        if (d_we) begin
                            mem_d_q  <= d_wdata;
                            mem_we_q <= 1'b1;
                            state_q  <= S_D_WR;
                        end else begin
                            state_q  <= S_D_MEM;
                        end
                    end else if (fetch_slot) begin
                        mem_addr_q <= pc_q;
                        state_q    <= S_F_MEM;
                    end
                end
                S_F_MEM: state_q <= S_F_CAP;
                S_F_CAP: begin
                    if (!jmp_valid) begin
                        ir_q       <= mem_q;
                        pc_ir_q    <= pc_q;
                        ir_valid_q <= 1'b1;
                        pc_q       <= pc_q + AW'(1);
                    end
                    state_q <= S_IDLE;
                end
                S_D_MEM: state_q <= S_D_CAP;
                S_D_CAP: begin
                    d_rdata_q  <= mem_q;
                    d_rvalid_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                S_D_WR:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
            // Redirect wins over fetch capture and IR consumption; data ops run on
            if (jmp_valid) begin
                pc_q       <= jmp_addr;
                ir_valid_q <= 1'b0;
                if (fetch_busy) begin
                    state_q <= S_IDLE;
                end
            end
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_d    = mem_d_q;
    assign mem_we   = mem_we_q;
    assign ir       = ir_q;
    assign pc_ir    = pc_ir_q;
    assign ir_valid = ir_valid_q;
    assign d_rdata  = d_rdata_q;
    assign d_rvalid = d_rvalid_q;

endmodule
